// File: rtl/pe_tile_param.sv
// Parametrised PE tile: four sides of TRACKS tracks, each WIDTH bits wide,
// two connect boxes, one switch box and a PE with an accumulator.
// Configuration is double-buffered: writes land in shadow registers and only
// take effect when a per-tile or broadcast COMMIT copies them into the
// active registers.
module pe_tile_param #(
   parameter int WIDTH  = 1,
   parameter int TRACKS = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [31:0]                  config_addr,
   input  logic [31:0]                  config_data,
   input  logic [15:0]                  tile_id,
   input  logic [4*TRACKS*WIDTH-1:0]    in_wires,
   output logic [4*TRACKS*WIDTH-1:0]    out_wires,
   output logic [WIDTH-1:0]             pe_out
);

   localparam int CBW = $clog2(2 * TRACKS);
   localparam int SBW = 8 * TRACKS;
   localparam int BUSW = 4 * TRACKS * WIDTH;

   localparam logic [15:0] FEAT_CLB    = 16'd4;
   localparam logic [15:0] FEAT_CB1    = 16'd5;
   localparam logic [15:0] FEAT_CB0    = 16'd6;
   localparam logic [15:0] FEAT_SB     = 16'd7;
   localparam logic [15:0] FEAT_COMMIT = 16'd8;

   typedef enum logic [2:0] {
      OP_ZERO = 3'd0,
      OP_AND  = 3'd1,
      OP_OR   = 3'd2,
      OP_XOR  = 3'd3,
      OP_ADD  = 3'd4,
      OP_SUB  = 3'd5,
      OP_ACC  = 3'd6,
      OP_PASS = 3'd7
   } opcode_e;

   logic [15:0]      featureId;
   logic [15:0]      targetId;
   logic             tileHit;
   logic             commitHit;

   logic [SBW-1:0]   sbShadow_q;
   logic [SBW-1:0]   sbActive_q;
   logic [CBW-1:0]   cb0Shadow_q;
   logic [CBW-1:0]   cb0Active_q;
   logic [CBW-1:0]   cb1Shadow_q;
   logic [CBW-1:0]   cb1Active_q;
   logic [3:0]       clbShadow_q;
   logic [3:0]       clbActive_q;

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] peReg_q;
   logic [WIDTH-1:0] peReg_d;

   opcode_e          opcode;
   logic             regMode;
   logic [BUSW-1:0]  routeOut;
   logic [BUSW-1:0]  cbView;
   logic [WIDTH-1:0] op0;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] aluResult;

   // Only a few config_data bits are consumed per feature; the rest are
   // gathered here so they are visibly accounted for.
   logic             unusedConfigBits;
   assign unusedConfigBits = ^config_data;

   assign featureId = config_addr[31:16];
   assign targetId  = config_addr[15:0];
   assign tileHit   = (targetId == tile_id);
   assign commitHit = (featureId == FEAT_COMMIT) && (tileHit || (targetId == 16'hFFFF));

   assign opcode  = opcode_e'(clbActive_q[2:0]);
   assign regMode = clbActive_q[3];

   // Shadow writes on a matching address, shadow-to-active copy on COMMIT.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sbShadow_q  <= '0;
         sbActive_q  <= '0;
         cb0Shadow_q <= '0;
         cb0Active_q <= '0;
         cb1Shadow_q <= '0;
         cb1Active_q <= '0;
         clbShadow_q <= '0;
         clbActive_q <= '0;
      end else begin
         if (tileHit) begin
            case (featureId)
               FEAT_SB:  sbShadow_q  <= config_data[SBW-1:0];
               FEAT_CB0: cb0Shadow_q <= config_data[CBW-1:0];
               FEAT_CB1: cb1Shadow_q <= config_data[CBW-1:0];
               FEAT_CLB: clbShadow_q <= config_data[3:0];
               default:  ;
            endcase
         end
         if (commitHit) begin
            sbActive_q  <= sbShadow_q;
            cb0Active_q <= cb0Shadow_q;
            cb1Active_q <= cb1Shadow_q;
            clbActive_q <= clbShadow_q;
         end
      end
   end

   // Switch box: each output picks pe_out or the same track on one of the
   // other three sides (ascending, own side skipped). The connect boxes see a
   // copy of this routing in which pe_out is replaced by the PE register, so
   // the netlist has no structural loop; the only configuration where that
   // differs from out_wires is the illegal REG=0 loop.
   always_comb begin
      logic [1:0] sel;
      int         src;
      routeOut = '0;
      cbView   = '0;
      sel      = '0;
      src      = 0;
      for (int s = 0; s < 4; s++) begin
         for (int t = 0; t < TRACKS; t++) begin
            sel = sbActive_q[2*(s*TRACKS+t) +: 2];
            if (sel == 2'd0) begin
               routeOut[(s*TRACKS+t)*WIDTH +: WIDTH] = pe_out;
               cbView[(s*TRACKS+t)*WIDTH +: WIDTH]   = peReg_q;
            end else begin
               src = (int'(sel) - 1 < s) ? int'(sel) - 1 : int'(sel);
               routeOut[(s*TRACKS+t)*WIDTH +: WIDTH] = in_wires[(src*TRACKS+t)*WIDTH +: WIDTH];
               cbView[(s*TRACKS+t)*WIDTH +: WIDTH]   = in_wires[(src*TRACKS+t)*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Connect boxes: CB0 reads side 0, CB1 reads side 1; low values pick an
   // input track, high values pick the matching output track.
   always_comb begin
      int v0;
      int v1;
      v0 = int'(cb0Active_q);
      v1 = int'(cb1Active_q);
      if (v0 < TRACKS) begin
         op0 = in_wires[v0*WIDTH +: WIDTH];
      end else begin
         op0 = cbView[(v0-TRACKS)*WIDTH +: WIDTH];
      end
      if (v1 < TRACKS) begin
         op1 = in_wires[(TRACKS+v1)*WIDTH +: WIDTH];
      end else begin
         op1 = cbView[v1*WIDTH +: WIDTH];
      end
   end

   // PE arithmetic, all modulo 2^WIDTH with no carry out.
   always_comb begin
      case (opcode)
         OP_ZERO: aluResult = '0;
         OP_AND:  aluResult = op0 & op1;
         OP_OR:   aluResult = op0 | op1;
         OP_XOR:  aluResult = op0 ^ op1;
         OP_ADD:  aluResult = op0 + op1;
         OP_SUB:  aluResult = op0 - op1;
         OP_ACC:  aluResult = acc_q;
         OP_PASS: aluResult = op0;
         default: aluResult = '0;
      endcase
   end

   assign acc_d   = acc_q + op0;
   assign peReg_d = aluResult;

   // Accumulator restarts from zero on every COMMIT and only runs under ACC;
   // the output register samples the PE result every cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_q   <= '0;
         peReg_q <= '0;
      end else begin
         peReg_q <= peReg_d;
         if (commitHit) begin
            acc_q <= '0;
         end else if (opcode == OP_ACC) begin
            acc_q <= acc_d;
         end
      end
   end

   assign pe_out    = regMode ? peReg_q : aluResult;
   assign out_wires = routeOut;

endmodule
